adc_scan_sequencer: RTL and testbench
=====================================

# adc_scan_sequencer

Sequencer that drives one `adc_capture` instance through a scan of a selectable subset of the ADC128S052 inputs IN0–IN7. Each scan can run once or repeat continuously. The block owns the capture's `en`, `address` and `adc_ack` inputs and compensates for the ADC's one-frame address-to-data lag. It emits tagged 12-bit results on a valid/ready stream toward the control logic. Downstream backpressure stalls the ADC, so no sample is dropped.

## Interface

Parameters:
- `TIMEOUT_CYC`, default 4096: clk cycles allowed in WAIT or ACK before the error abort.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock; same clock as `adc_capture`.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  start-scan request; sampled in IDLE only.
- `continuous`  in  1  sampled with `start`; 1 means repeat scans until `stop`.
- `stop`  in  1  request to end a continuous scan.
- `ch_mask`  in  8  enabled channels, bit i = IN i; sampled with `start`.
- `adc_en`  out  1  drives capture `en`.
- `adc_address`  out  3  drives capture `address`.
- `adc_ready`  in  1  from capture.
- `adc_data`  in  12  from capture `d_signal`.
- `adc_ack`  out  1  drives capture `adc_ack`.
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  downstream accept.
- `res_channel`  out  3  channel number of `res_data`.
- `res_data`  out  12  conversion result.
- `busy`  out  1  1 in any state other than IDLE.
- `scan_done`  out  1  one-cycle pulse at the end of each completed scan.
- `err`  out  1  sticky timeout flag.

## Operation

- Reset values: `adc_en` = 0, `adc_address` = 0, `adc_ack` = 0, `res_valid` = 0, `res_channel` = 0, `res_data` = 0, `busy` = 0, `scan_done` = 0, `err` = 0. The FSM enters IDLE.
- A reset mid-scan aborts the scan immediately. The latched mask and both channel pointers are cleared.
- Internal channel pointers:
  - `cur` is the channel being selected; it equals `adc_address`.
  - `prev` is the channel whose data the current frame returns.
  - `prime` marks the first frame of a scan, whose data is discarded.
- "Next channel" means the next set bit of the latched mask above `cur`, wrapping around from 7 to 0.
- FSM states and transitions:
  - IDLE: on `start` = 1 with a nonzero `ch_mask`:
    - latch `ch_mask` and `continuous`;
    - set `adc_address` to the lowest set bit;
    - set `prime` = 1, clear `err`, set `adc_en` = 1;
    - go to WAIT.
  - IDLE, `start` with `ch_mask` = 0: ignored. No state change, no `scan_done`, `err` unchanged.
  - WAIT: on `adc_ready` = 1:
    - if `prime` = 1, go to ACK;
    - otherwise latch `res_data` = `adc_data` and `res_channel` = `prev`, assert `res_valid`, go to OUT.
  - OUT: hold `res_valid` and its data until `res_valid` && `res_ready`. Then drop `res_valid` and go to ACK.
  - ACK:
    - On entry: assert `adc_ack`, set `prev` ← `cur`, advance `cur`/`adc_address` to the next channel, clear `prime`.
    - Hold `adc_ack` until `adc_ready` is sampled 0, then deassert it.
    - If the result just delivered was from the last enabled channel (highest set bit), pulse `scan_done` and go to END.
    - Otherwise go to WAIT.
  - END:
    - If the latched `continuous` = 1 and `stop` is not pending, go to WAIT without re-priming. The pipeline stays valid because `cur` has already wrapped to the lowest channel.
    - Otherwise drop `adc_en` and go to IDLE.
- Single-channel mask: the next channel is always the same channel.
- Frame counts: a single scan with N enabled channels uses N+1 ADC frames. In continuous mode each further scan uses N frames.
- `stop`:
  - Latched as pending whenever it is seen high while `busy`.
  - Acted on only at END; the current scan always completes.
  - Cleared on the IDLE entry.
  - Ignored in IDLE.
- `start` while `busy`: ignored.
- Timeout:
  - A counter counts cycles spent in WAIT or ACK and resets on every state change.
  - When it reaches `TIMEOUT_CYC`:
    - set `err` = 1;
    - drop `adc_en`, `adc_ack` and `res_valid`;
    - go to IDLE;
    - no `scan_done`.
  - The timeout does not run in OUT; downstream may stall indefinitely.
- `adc_address` changes only on ACK entry, i.e. while `adc_ready` = 1. The capture is then idle, so the address is stable for the whole following frame.

## Timing

- Start: `start` is sampled high at edge k → `busy`, `adc_en` = 1 and `adc_address` are valid after edge k.
- Result: `adc_ready` is sampled high at edge k (non-prime frame) → `res_valid` = 1 after edge k.
- Acknowledge: the accept handshake at edge k → `res_valid` = 0, `adc_ack` = 1 and the new `adc_address` all appear after edge k.
- `adc_ack` stays high for as many cycles as the capture needs to sample it. The capture samples it on its slow internal clock.
- `scan_done` is high for exactly one cycle, on the ACK→END transition.
- `res_channel`/`res_data` stay stable while `res_valid` = 1 and `res_ready` = 0.

## Test plan

- Reset: assert `rst` = 0 mid-scan while `res_valid` = 1 → all outputs return to their reset values on the same edge. The FSM is in IDLE after release.
- Single scan, `ch_mask` = 8'b0000_0101, ADC model returning 12'h100 + selected address with one-frame lag, `res_ready` = 1:
  - 3 frames;
  - results (ch0, 12'h100) then (ch2, 12'h102);
  - one `scan_done`;
  - `adc_en` then drops.
- Backpressure: same scan with `res_ready` held 0 for 500 cycles → `res_valid` and data stay stable, `adc_ack` stays 0, no `err`, and there is no second result until accept.
- Continuous, `ch_mask` = 8'h80, `stop` pulsed during the third result → results ch7, ch7, ch7 with 2 frames then 1 frame each, three `scan_done` pulses, then IDLE.
- Timeout, `TIMEOUT_CYC` = 64, ADC model never raises `adc_ready` → `err` = 1 after 64 cycles in WAIT, `adc_en` = 0, IDLE, no `scan_done`. A following valid `start` clears `err`.
- `start` with `ch_mask` = 0 → `busy` stays 0, `adc_en` stays 0, no outputs change.

Source files
------------

// File: rtl/adc_scan_sequencer.sv
// Scan sequencer for one adc_capture instance: walks the enabled ADC128S052 channels,
// hides the one-frame address-to-data lag and streams tagged results with backpressure.
module adc_scan_sequencer #(
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        continuous,
  input  logic        stop,
  input  logic [7:0]  ch_mask,
  output logic        adc_en,
  output logic [2:0]  adc_address,
  input  logic        adc_ready,
  input  logic [11:0] adc_data,
  output logic        adc_ack,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [2:0]  res_channel,
  output logic [11:0] res_data,
  output logic        busy,
  output logic        scan_done,
  output logic        err
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StWait = 3'd1;
  localparam logic [2:0] StOut  = 3'd2;
  localparam logic [2:0] StAck  = 3'd3;
  localparam logic [2:0] StEnd  = 3'd4;

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  logic [2:0]      state_q, state_d;
  logic [7:0]      mask_q, mask_d;
  logic            cont_q, cont_d;
  logic            prime_q, prime_d;
  logic            stop_pend_q, stop_pend_d;
  logic            last_q, last_d;
  logic [2:0]      cur_q, cur_d;
  logic [2:0]      prev_q, prev_d;
  logic            en_q, en_d;
  logic            ack_q, ack_d;
  logic            valid_q, valid_d;
  logic [2:0]      chan_q, chan_d;
  logic [11:0]     data_q, data_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_hit;
  logic            abort;

  function automatic logic [2:0] lowest(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  function automatic logic [2:0] highest(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Smallest wrapping offset wins; falls back to c itself for a single-channel mask.
  function automatic logic [2:0] next_ch(input logic [7:0] m, input logic [2:0] c);
    logic [2:0] r;
    logic [2:0] k;
    r = c;
    for (int i = 7; i >= 1; i--) begin
      k = c + 3'(i);
      if (m[k]) r = k;
    end
    return r;
  endfunction

  assign timeout_hit = (cnt_q == CntW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    cont_d      = cont_q;
    prime_d     = prime_q;
    stop_pend_d = stop_pend_q;
    last_d      = last_q;
    cur_d       = cur_q;
    prev_d      = prev_q;
    en_d        = en_q;
    ack_d       = ack_q;
    valid_d     = valid_q;
    chan_d      = chan_q;
    data_d      = data_q;
    done_d      = 1'b0;
    err_d       = err_q;
    abort       = 1'b0;

    if (state_q != StIdle && stop) stop_pend_d = 1'b1;

    case (state_q)
      StIdle: begin
        stop_pend_d = 1'b0;
        if (start && (ch_mask != 8'd0)) begin
          mask_d  = ch_mask;
          cont_d  = continuous;
          cur_d   = lowest(ch_mask);
          prime_d = 1'b1;
          err_d   = 1'b0;
          en_d    = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        if (adc_ready) begin
          if (prime_q) begin
            ack_d   = 1'b1;
            prev_d  = cur_q;
            cur_d   = next_ch(mask_q, cur_q);
            prime_d = 1'b0;
            last_d  = 1'b0;
            state_d = StAck;
          end else begin
            data_d  = adc_data;
            chan_d  = prev_q;
            valid_d = 1'b1;
            state_d = StOut;
          end
        end else if (timeout_hit) begin
          abort = 1'b1;
        end
      end
      StOut: begin
        if (res_ready) begin
          valid_d = 1'b0;
          ack_d   = 1'b1;
          prev_d  = cur_q;
          cur_d   = next_ch(mask_q, cur_q);
          prime_d = 1'b0;
          last_d  = (chan_q == highest(mask_q));
          state_d = StAck;
        end
      end
      StAck: begin
        if (!adc_ready) begin
          ack_d = 1'b0;
          if (last_q) begin
            done_d  = 1'b1;
            state_d = StEnd;
          end else begin
            state_d = StWait;
          end
        end else if (timeout_hit) begin
          abort = 1'b1;
        end
      end
      StEnd: begin
        // cur already points one frame ahead, so a repeat scan needs no re-prime.
        if (cont_q && !stop_pend_q && !stop) begin
          state_d = StWait;
        end else begin
          en_d        = 1'b0;
          stop_pend_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      err_d       = 1'b1;
      en_d        = 1'b0;
      ack_d       = 1'b0;
      valid_d     = 1'b0;
      stop_pend_d = 1'b0;
      state_d     = StIdle;
    end

    if ((state_d != state_q) || !((state_q == StWait) || (state_q == StAck))) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      mask_q      <= 8'd0;
      cont_q      <= 1'b0;
      prime_q     <= 1'b0;
      stop_pend_q <= 1'b0;
      last_q      <= 1'b0;
      cur_q       <= 3'd0;
      prev_q      <= 3'd0;
      en_q        <= 1'b0;
      ack_q       <= 1'b0;
      valid_q     <= 1'b0;
      chan_q      <= 3'd0;
      data_q      <= 12'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      cont_q      <= cont_d;
      prime_q     <= prime_d;
      stop_pend_q <= stop_pend_d;
      last_q      <= last_d;
      cur_q       <= cur_d;
      prev_q      <= prev_d;
      en_q        <= en_d;
      ack_q       <= ack_d;
      valid_q     <= valid_d;
      chan_q      <= chan_d;
      data_q      <= data_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign adc_en      = en_q;
  assign adc_address = cur_q;
  assign adc_ack     = ack_q;
  assign res_valid   = valid_q;
  assign res_channel = chan_q;
  assign res_data    = data_q;
  assign busy        = (state_q != StIdle);
  assign scan_done   = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer with a lagging ADC capture model
// (data = 12'h100 + address of the previous frame).
module tb_adc_scan_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        continuous;
  logic        stop;
  logic [7:0]  ch_mask;
  logic        adc_en;
  logic [2:0]  adc_address;
  logic        adc_ready;
  logic [11:0] adc_data;
  logic        adc_ack;
  logic        res_valid;
  logic        res_ready;
  logic [2:0]  res_channel;
  logic [11:0] res_data;
  logic        busy;
  logic        scan_done;
  logic        err;

  int checks = 0;
  int failures = 0;

  logic        model_on;
  int          mst;
  int          mcnt;
  logic [2:0]  frame_addr;
  logic [2:0]  lag_addr;
  int          frames;
  int          done_cnt = 0;
  logic [14:0] res_q[$];
  int          frm_q[$];

  adc_scan_sequencer #(
    .TIMEOUT_CYC(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .continuous(continuous),
    .stop(stop),
    .ch_mask(ch_mask),
    .adc_en(adc_en),
    .adc_address(adc_address),
    .adc_ready(adc_ready),
    .adc_data(adc_data),
    .adc_ack(adc_ack),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_channel(res_channel),
    .res_data(res_data),
    .busy(busy),
    .scan_done(scan_done),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ADC capture model: 8-cycle frame, holds ready until ack, then waits for ack low.
  initial begin
    adc_ready  = 1'b0;
    adc_data   = 12'd0;
    mst        = 0;
    mcnt       = 0;
    frame_addr = 3'd0;
    lag_addr   = 3'd0;
    frames     = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        adc_ready = 1'b0;
        mst       = 0;
      end else begin
        case (mst)
          0: if (model_on && adc_en && !adc_ack) begin
            frame_addr = adc_address;
            mcnt       = 0;
            mst        = 1;
          end
          1: begin
            mcnt++;
            if (!adc_en) begin
              mst = 0;
            end else if (mcnt == 8) begin
              adc_data  = 12'h100 + {9'd0, lag_addr};
              lag_addr  = frame_addr;
              adc_ready = 1'b1;
              frames++;
              mst       = 2;
            end
          end
          2: if (adc_ack || !adc_en) begin
            adc_ready = 1'b0;
            mst       = 3;
          end
          default: if (!adc_ack) mst = 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (rst && res_valid && res_ready) begin
      res_q.push_back({res_channel, res_data});
      frm_q.push_back(frames);
    end
    if (rst && scan_done) done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!res_valid && n < 400) begin
      step();
      n++;
    end
    check(tag, {31'd0, res_valid}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 400) begin
      step();
      n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int rb;
    int d0;
    int f0;
    int bad;
    rst        = 1'b0;
    start      = 1'b0;
    continuous = 1'b0;
    stop       = 1'b0;
    ch_mask    = 8'd0;
    res_ready  = 1'b0;
    model_on   = 1'b1;
    repeat (3) step();
    check("reset_outs", {8'd0, adc_en, adc_address, adc_ack, res_valid, res_channel, res_data,
                         busy, scan_done, err}, 32'd0);
    rst = 1'b1;
    step();

    // Zero mask start is ignored.
    ch_mask = 8'd0;
    start   = 1'b1;
    step();
    start = 1'b0;
    check("zmask_busy", {31'd0, busy}, 32'd0);
    check("zmask_en", {31'd0, adc_en}, 32'd0);
    repeat (3) step();
    check("zmask_quiet", {29'd0, busy, adc_en, scan_done}, 32'd0);

    // Single scan IN0, IN2 with res_ready high.
    rb = res_q.size(); d0 = done_cnt; f0 = frames;
    res_ready = 1'b1;
    ch_mask   = 8'b0000_0101;
    start     = 1'b1;
    step();
    start = 1'b0;
    check("single_start", {27'd0, busy, adc_en, adc_address}, {27'd0, 1'b1, 1'b1, 3'd0});
    wait_idle("single_idle");
    check("single_frames", frames - f0, 32'd3);
    check("single_nres", res_q.size() - rb, 32'd2);
    check("single_res0", {17'd0, res_q[rb]}, {17'd0, 15'h0100});
    check("single_res1", {17'd0, res_q[rb + 1]}, {17'd0, 15'h2102});
    check("single_done", done_cnt - d0, 32'd1);
    check("single_en_off", {30'd0, adc_en, err}, 32'd0);

    // Backpressure: hold the first result for 500 cycles.
    rb = res_q.size(); d0 = done_cnt;
    res_ready = 1'b0;
    start     = 1'b1;
    step();
    start = 1'b0;
    wait_valid("bp_valid");
    check("bp_first", {17'd0, res_channel, res_data}, {17'd0, 15'h0100});
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      step();
      if (res_valid !== 1'b1 || res_channel !== 3'd0 || res_data !== 12'h100 ||
          adc_ack !== 1'b0 || err !== 1'b0) bad++;
    end
    check("bp_stable", bad, 32'd0);
    check("bp_no_accept", res_q.size() - rb, 32'd0);
    res_ready = 1'b1;
    wait_idle("bp_idle");
    check("bp_nres", res_q.size() - rb, 32'd2);
    check("bp_res1", {17'd0, res_q[rb + 1]}, {17'd0, 15'h2102});
    check("bp_done", done_cnt - d0, 32'd1);

    // Continuous IN7, stop during the third result.
    rb = res_q.size(); d0 = done_cnt; f0 = frames;
    res_ready  = 1'b0;
    ch_mask    = 8'h80;
    continuous = 1'b1;
    start      = 1'b1;
    step();
    start      = 1'b0;
    continuous = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_valid("cont_valid");
      res_ready = 1'b1;
      if (i == 2) stop = 1'b1;
      step();
      res_ready = 1'b0;
      stop      = 1'b0;
    end
    wait_idle("cont_idle");
    check("cont_nres", res_q.size() - rb, 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("cont_res", {17'd0, res_q[rb + i]}, {17'd0, 15'h7107});
      check("cont_frames", frm_q[rb + i] - f0, i + 2);
    end
    check("cont_done", done_cnt - d0, 32'd3);
    check("cont_total_frames", frames - f0, 32'd4);

    // Timeout: ADC never answers.
    d0 = done_cnt;
    model_on = 1'b0;
    ch_mask  = 8'h01;
    start    = 1'b1;
    step();
    start = 1'b0;
    check("to_busy", {31'd0, busy}, 32'd1);
    repeat (63) step();
    check("to_before", {30'd0, busy, err}, {30'd0, 1'b1, 1'b0});
    step();
    check("to_after", {29'd0, busy, adc_en, err}, {29'd0, 1'b0, 1'b0, 1'b1});
    check("to_no_done", done_cnt - d0, 32'd0);
    model_on = 1'b1;
    start    = 1'b1;
    step();
    start = 1'b0;
    check("to_clear", {30'd0, busy, err}, {30'd0, 1'b1, 1'b0});
    res_ready = 1'b1;
    wait_idle("to_recover_idle");

    // Asynchronous reset while a result is pending.
    res_ready = 1'b0;
    ch_mask   = 8'b0000_0101;
    start     = 1'b1;
    step();
    start = 1'b0;
    wait_valid("rst_valid");
    #1 rst = 1'b0;
    #1;
    check("rst_mid_outs", {8'd0, adc_en, adc_address, adc_ack, res_valid, res_channel, res_data,
                           busy, scan_done, err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) step();
    check("rst_idle", {30'd0, busy, adc_en}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
